// File: rtl/nq_sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nq_bus_pkg
// Description : Shared types and constants for the nqcpu memory-side bridge.
//               Holds the bridge FSM state encoding, the wait-state counter
//               width and a helper that turns a wait-state count into the
//               counter load value.
// Revision    : 1.0 - initial release
// ============================================================================
package nq_bus_pkg;

    // Bridge FSM states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bridge_state_t;

    // Wait-state counter width; covers wait counts 1..15.
    localparam int WAIT_CNT_W = 4;

    // The counter is loaded with WAIT-1 and the access finishes in the
    // cycle where it reads zero, so the strobe is active for WAIT cycles.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wait_cycles);
        return WAIT_CNT_W'(wait_cycles - 1);
    endfunction

endpackage : nq_bus_pkg
`default_nettype wire

// File: rtl/nq_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : nq_sram_bridge_if
// Description : CPU-side bus between nqcpu and the SRAM bridge.
//               master : the CPU (drives address, level-held re/we, wdata)
//               slave  : the bridge (returns rdata, rdata_oe, needWait)
//   cpu_addr_i   [23:0] byte address, bit 0 ignored
//   cpu_re_i            read request, held until needWait_o low
//   cpu_we_i            write request, held until needWait_o low
//   cpu_wdata_i  [15:0] write data
//   cpu_rdata_o  [15:0] read data
//   cpu_rdata_oe        tristate enable for read data onto the CPU bus
//   needWait_o          stall to the CPU
// Revision    : 1.0 - initial release
// ============================================================================
interface nq_sram_bridge_if;

    logic [23:0] cpu_addr_i;
    logic        cpu_re_i;
    logic        cpu_we_i;
    logic [15:0] cpu_wdata_i;
    logic [15:0] cpu_rdata_o;
    logic        cpu_rdata_oe;
    logic        needWait_o;

    modport master (
        output cpu_addr_i,
        output cpu_re_i,
        output cpu_we_i,
        output cpu_wdata_i,
        input  cpu_rdata_o,
        input  cpu_rdata_oe,
        input  needWait_o
    );

    modport slave (
        input  cpu_addr_i,
        input  cpu_re_i,
        input  cpu_we_i,
        input  cpu_wdata_i,
        output cpu_rdata_o,
        output cpu_rdata_oe,
        output needWait_o
    );

endinterface : nq_sram_bridge_if
`default_nettype wire

// File: rtl/nq_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : nq_sram_bridge
// Description : Converts the CPU's level-held re/we requests into timed
//               asynchronous-SRAM cycles with programmable wait states and
//               stalls the CPU via needWait_o until each access completes.
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cpu               CPU bus (slave modport of nq_sram_bridge_if)
//   sram_addr_o       word address (latched cpu_addr_i[23:1])
//   sram_ce_n/oe_n/we_n  active-low SRAM strobes (registered, glitch-free)
//   sram_dq_i/o, sram_dq_oe  SRAM data in / out / output drive enable
//   err_o             sticky protocol error (re&we together or request
//                     dropped mid-access), cleared only by rst
// Parameters  : READ_WAIT  read strobe cycles before capture (1..15)
//               WRITE_WAIT write-enable low cycles (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module nq_sram_bridge
    import nq_bus_pkg::*;
#(
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    nq_sram_bridge_if.slave  cpu,
    output logic [22:0]      sram_addr_o,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    input  wire logic [15:0] sram_dq_i,
    output logic [15:0]      sram_dq_o,
    output logic             sram_dq_oe,
    output logic             err_o
);

    localparam logic [WAIT_CNT_W-1:0] c_rd_load = wait_load(READ_WAIT);
    localparam logic [WAIT_CNT_W-1:0] c_wr_load = wait_load(WRITE_WAIT);

    bridge_state_t           r_state;
    bridge_state_t           w_next_state;
    logic [WAIT_CNT_W-1:0]   r_cnt;
    logic                    r_op_wr;
    logic [22:0]             r_addr;
    logic [15:0]             r_wdata;
    logic [15:0]             r_rdata;
    logic                    r_rdata_oe;
    logic                    r_ce_n;
    logic                    r_oe_n;
    logic                    r_we_n;
    logic                    r_dq_oe;
    logic                    r_err;

    logic                    w_req;
    logic                    w_start;
    logic                    w_cnt_zero;
    logic                    w_abort;
    logic                    w_capture;
    logic                    w_next_wr;
    logic                    w_next_busy;
    logic                    w_unused_addr_lsb;

    assign w_req      = cpu.cpu_re_i | cpu.cpu_we_i;
    assign w_start    = (r_state == IDLE) & w_req;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_abort    = (r_state == ACCESS) & ~w_req;
    assign w_capture  = (r_state == ACCESS) & w_req & w_cnt_zero & ~r_op_wr;

    // Operation of the state being entered: a new access takes its op from
    // the bus (write wins over read), otherwise the latched op persists.
    assign w_next_wr   = w_start ? cpu.cpu_we_i : r_op_wr;
    assign w_next_busy = (w_next_state == ACCESS) | (w_next_state == DONE);

    // Word access only; the byte-select bit is deliberately dropped.
    assign w_unused_addr_lsb = cpu.cpu_addr_i[0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!w_req) begin
                    w_next_state = IDLE;
                end else if (w_cnt_zero) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // One-cycle acknowledge; a request seen afterwards is new.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, wait counter and registered SRAM strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op_wr    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rdata_oe <= 1'b0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_dq_oe    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_start) begin
                r_op_wr <= cpu.cpu_we_i;
                r_addr  <= cpu.cpu_addr_i[23:1];
                r_wdata <= cpu.cpu_wdata_i;
                r_cnt   <= cpu.cpu_we_i ? c_wr_load : c_rd_load;
            end else if ((r_state == ACCESS) && !w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_capture) begin
                r_rdata <= sram_dq_i;
            end

            if ((w_start && cpu.cpu_re_i && cpu.cpu_we_i) || w_abort) begin
                r_err <= 1'b1;
            end

            // Strobes are decoded from the next state so they change exactly
            // on the edge that enters/leaves ACCESS and DONE. In DONE the
            // chip stays selected while oe_n/we_n rise, and write data stays
            // driven to give the SRAM its data-hold time.
            r_ce_n     <= ~w_next_busy;
            r_oe_n     <= ~((w_next_state == ACCESS) & ~w_next_wr);
            r_we_n     <= ~((w_next_state == ACCESS) &  w_next_wr);
            r_dq_oe    <= w_next_busy & w_next_wr;
            r_rdata_oe <= (w_next_state == DONE) & ~w_next_wr;
        end
    end

    // Stall is combinational so the CPU is held in the very cycle it raises
    // a request; reset holds the CPU regardless of the request lines.
    assign cpu.needWait_o   = rst | (w_req & (r_state != DONE));
    assign cpu.cpu_rdata_o  = r_rdata;
    assign cpu.cpu_rdata_oe = r_rdata_oe;

    assign sram_addr_o = r_addr;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign sram_dq_o   = r_wdata;
    assign sram_dq_oe  = r_dq_oe;
    assign err_o       = r_err;

endmodule : nq_sram_bridge
`default_nettype wire

// File: tb/tb_nq_sram_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_nq_sram_bridge
// Description : Self-checking bench for nq_sram_bridge with a behavioural
//               async SRAM (combinational read, write on rising we_n).
//               Table of directed accesses plus hand-written sequences for
//               back-to-back, re&we, abort and reset-mid-write corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nq_sram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [22:0] sram_addr;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nq_sram_bridge_if bus();

    nq_sram_bridge #(
        .READ_WAIT  (2),
        .WRITE_WAIT (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (bus.slave),
        .sram_addr_o (sram_addr),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_dq_i   (sram_dq_i),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_oe  (sram_dq_oe),
        .err_o       (err)
    );

    // Behavioural SRAM: 512 words; a write completes on the rising edge of
    // we_n while the chip is selected and reset is not asserted.
    logic [15:0] mem [0:511];
    assign sram_dq_i = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr[8:0]] : 16'hDEAD;
    always @(posedge sram_we_n) begin
        if (rst === 1'b0 && sram_ce_n === 1'b0) mem[sram_addr[8:0]] = sram_dq_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one access starting at posedge+1 of its request cycle. Returns the
    // number of needWait-high cycles, strobe-low counts and a DONE-cycle
    // snapshot; exits at posedge+1 of the following (IDLE) cycle with the
    // request still held so the caller may chain a new one.
    task automatic run_access(input logic re, input logic we,
                              input logic [23:0] addr, input logic [15:0] wd,
                              output int waits, output int oe_low, output int we_low,
                              output logic [22:0] sa, output logic [15:0] rd,
                              output logic rdoe, output logic dqoe,
                              output logic [15:0] dqo, output logic cen);
        bus.cpu_re_i    = re;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wd;
        #1;
        waits = 0; oe_low = 0; we_low = 0;
        while (bus.needWait_o && waits < 40) begin
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            waits++;
            @(posedge clk); #1;
        end
        sa   = sram_addr;
        rd   = bus.cpu_rdata_o;
        rdoe = bus.cpu_rdata_oe;
        dqoe = sram_dq_oe;
        dqo  = sram_dq_o;
        cen  = sram_ce_n;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        re;
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        int          exp_wait;
        int          exp_oe;
        int          exp_we;
        logic [22:0] exp_saddr;
        logic [15:0] exp_rdata;
        logic        exp_rdoe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          w, ol, wl, c0;
        logic [22:0] sa;
        logic [15:0] rd, dqo;
        logic        rdoe, dqoe, cen;

        bus.cpu_re_i = 1'b0; bus.cpu_we_i = 1'b0;
        bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h082] = 16'hBEEF;
        mem[9'h000] = 16'h1111;
        mem[9'h100] = 16'h2222;

        //                re    we    addr        wdata    wt oe we saddr      rdata    rdoe
        vecs[0] = '{1'b1, 1'b0, 24'h000104, 16'h0000, 3, 2, 0, 23'h000082, 16'hBEEF, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 24'h000010, 16'h1234, 2, 0, 1, 23'h000008, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 24'h000011, 16'h0000, 3, 2, 0, 23'h000008, 16'h1234, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 24'h0001FE, 16'hCAFE, 2, 0, 1, 23'h0000FF, 16'h1234, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 24'h0001FE, 16'h0000, 3, 2, 0, 23'h0000FF, 16'hCAFE, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 24'h000105, 16'h0000, 3, 2, 0, 23'h000082, 16'hBEEF, 1'b1};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_needwait", bus.needWait_o, 1);
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_saddr", sram_addr, 0);
        check("rst_rdata", bus.cpu_rdata_o, 0);
        check("rst_rdata_oe", bus.cpu_rdata_oe, 0);
        check("rst_err", err, 0);
        bus.cpu_re_i = 1'b1;
        @(posedge clk); #1;
        check("rst_req_needwait", bus.needWait_o, 1);
        check("rst_req_ce_n", sram_ce_n, 1);
        bus.cpu_re_i = 1'b0;
        rst = 1'b0;
        #1;
        check("idle_needwait", bus.needWait_o, 0);
        @(posedge clk); #1;

        // ---------------- table of accesses (back-to-back) ----------------
        for (int i = 0; i < 6; i++) begin
            run_access(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       w, ol, wl, sa, rd, rdoe, dqoe, dqo, cen);
            check($sformatf("v%0d_waits", i), w, vecs[i].exp_wait);
            check($sformatf("v%0d_oe_low", i), ol, vecs[i].exp_oe);
            check($sformatf("v%0d_we_low", i), wl, vecs[i].exp_we);
            check($sformatf("v%0d_saddr", i), sa, vecs[i].exp_saddr);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_rdata_oe", i), rdoe, vecs[i].exp_rdoe);
            check($sformatf("v%0d_dq_oe", i), dqoe, vecs[i].we);
            check($sformatf("v%0d_ce_n", i), cen, 0);
            if (vecs[i].we) check($sformatf("v%0d_dq_o", i), dqo, vecs[i].wdata);
        end
        bus.cpu_re_i = 1'b0; bus.cpu_we_i = 1'b0;
        check("tbl_err", err, 0);
        check("mem_w8", mem[9'h008], 16'h1234);
        check("mem_wff", mem[9'h0FF], 16'hCAFE);

        // ---------------- back-to-back reads ----------------
        @(posedge clk); #1;
        c0 = cyc;
        run_access(1'b1, 1'b0, 24'h000000, 16'h0, w, ol, wl, sa, rd, rdoe, dqoe, dqo, cen);
        check("b2b_rd0", rd, 16'h1111);
        run_access(1'b1, 1'b0, 24'h000200, 16'h0, w, ol, wl, sa, rd, rdoe, dqoe, dqo, cen);
        check("b2b_rd1", rd, 16'h2222);
        check("b2b_saddr1", sa, 23'h000100);
        check("b2b_cycles", cyc - c0, 8);
        bus.cpu_re_i = 1'b0;

        // ---------------- re & we together ----------------
        @(posedge clk); #1;
        run_access(1'b1, 1'b1, 24'h000020, 16'hA5A5, w, ol, wl, sa, rd, rdoe, dqoe, dqo, cen);
        bus.cpu_re_i = 1'b0; bus.cpu_we_i = 1'b0;
        check("both_waits", w, 2);
        check("both_we_low", wl, 1);
        check("both_oe_low", ol, 0);
        check("both_rdata_oe", rdoe, 0);
        check("both_err", err, 1);
        check("both_mem", mem[9'h010], 16'hA5A5);
        run_access(1'b1, 1'b0, 24'h000020, 16'h0, w, ol, wl, sa, rd, rdoe, dqoe, dqo, cen);
        bus.cpu_re_i = 1'b0;
        check("both_readback", rd, 16'hA5A5);
        check("err_sticky", err, 1);

        // ---------------- reset clears err ----------------
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst2_err", err, 0);
        check("rst2_rdata", bus.cpu_rdata_o, 0);

        // ---------------- request dropped during ACCESS ----------------
        @(posedge clk); #1;
        bus.cpu_re_i = 1'b1; bus.cpu_addr_i = 24'h000104;
        @(posedge clk); #1;
        check("abort_oe_low", sram_oe_n, 0);
        bus.cpu_re_i = 1'b0;
        @(posedge clk); #1;
        check("abort_oe_n", sram_oe_n, 1);
        check("abort_ce_n", sram_ce_n, 1);
        check("abort_err", err, 1);
        check("abort_rdata", bus.cpu_rdata_o, 0);
        check("abort_needwait", bus.needWait_o, 0);
        run_access(1'b1, 1'b0, 24'h000104, 16'h0, w, ol, wl, sa, rd, rdoe, dqoe, dqo, cen);
        bus.cpu_re_i = 1'b0;
        check("post_abort_waits", w, 3);
        check("post_abort_rdata", rd, 16'hBEEF);

        // ---------------- reset mid-write ----------------
        bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 24'h000010; bus.cpu_wdata_i = 16'h5555;
        @(posedge clk); #1;
        check("rmw_we_low", sram_we_n, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rmw_we_n", sram_we_n, 1);
        check("rmw_ce_n", sram_ce_n, 1);
        check("rmw_dq_oe", sram_dq_oe, 0);
        check("rmw_needwait", bus.needWait_o, 1);
        @(posedge clk); #1;
        check("rmw_needwait_hold", bus.needWait_o, 1);
        bus.cpu_we_i = 1'b0;
        rst = 1'b0;
        #1;
        check("rmw_needwait_rel", bus.needWait_o, 0);
        check("rmw_mem", mem[9'h008], 16'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nq_sram_bridge
`default_nettype wire
